uart_crc_top: RTL and testbench
===============================

Name: uart_crc_top

Overview:
Self-contained UART link with CRC-16 error detection, used as a loopback test block.
- A UART transmitter sends one data byte followed by its CRC-16 (two bytes) on an internal serial line.
- A UART receiver on the same line deserializes the three bytes, re-checks the CRC, and presents the data byte plus a validity flag.

Parameters:
- CLKS_PER_BIT, 4: clock cycles per UART bit. Legal range 2..65535.
- CRC_INIT, 16'hFFFF: CRC register seed, used by both TX and RX.

Ports:
- clk  in  1  system clock. All logic is on its rising edge.
- reset  in  1  asynchronous, active-low reset. 0 = reset.
- tx_data_in  in  8  byte to transmit. Sampled on the cycle tx_start=1 is accepted.
- tx_start  in  1  single-cycle start request. Ignored while the transmitter is busy.
- rx_data_out  out  8  last received data byte.
- rx_ready_out  out  1  level; high = a complete frame has been received.
- crc_valid_out  out  1  level; high = the received frame passed the CRC check. Meaningful only while rx_ready_out=1.

Behaviour:
- Reset (reset=0, async):
  - Serial line idles high.
  - TX and RX state machines return to IDLE.
  - rx_data_out=0, rx_ready_out=0, crc_valid_out=0.
  - Reset mid-frame aborts the frame; nothing is reported.
- CRC algorithm: CRC-16/CCITT, polynomial 0x1021, MSB-first, no reflection, no final XOR, seeded with CRC_INIT. Check value for ASCII "123456789" is 0x29B1.
- Frame: three 8N1 UART bytes, sent back-to-back with no idle gap:
  - byte 0 = data
  - byte 1 = CRC[15:8]
  - byte 2 = CRC[7:0]
  - Each byte: start bit 0, 8 data bits LSB first, stop bit 1; every bit lasts CLKS_PER_BIT cycles.
- TX state machine: IDLE -> START -> DATA(8) -> STOP, repeated for each of the 3 bytes, then IDLE.
  - In IDLE, tx_start=1 latches tx_data_in and computes the CRC over that one byte.
  - The line goes low on the next cycle.
  - tx_start while not in IDLE is ignored.
- RX state machine: IDLE -> START -> DATA -> STOP, repeated per byte.
  - A falling edge on the line in IDLE starts the start bit.
  - Start bit is re-sampled at mid-bit (CLKS_PER_BIT/2); if it reads 1, it is a glitch and RX returns to IDLE.
  - Data bits are sampled at mid-bit.
  - The RX CRC runs over all 3 received bytes from CRC_INIT; a correct frame leaves remainder 0.
- Completion: on the cycle the byte-2 stop bit is sampled:
  - rx_data_out <= byte 0
  - crc_valid_out <= (remainder==0) and all stop bits were 1
  - rx_ready_out <= 1
- Framing error (any stop bit sampled 0): the frame ends immediately; rx_ready_out=1, crc_valid_out=0, rx_data_out keeps its old value.
- Hold and clear: rx_ready_out, crc_valid_out and rx_data_out hold until the start bit of the next frame is detected. At that point rx_ready_out and crc_valid_out clear; rx_data_out holds.
- Latency: from tx_start accepted to rx_ready_out=1 is 30*CLKS_PER_BIT - CLKS_PER_BIT/2 + 2 cycles, ±1 cycle.

Optional Feature:
- Macro: UART_CRC_ERR_INJECT_EN.
- When defined:
  - Adds input port err_inject_in (1 bit), sampled together with tx_start.
  - If err_inject_in=1, data bit 0 of byte 0 is inverted on the line only; the TX CRC is still computed on the true byte.
  - Result: the receiver reports crc_valid_out=0.
- When undefined: the port does not exist and the line carries the frame unmodified.

Decomposition:
- Package uart_crc_pkg holds:
  - CRC16_POLY = 16'h1021
  - FRAME_BYTES = 3
  - TX/RX state enum typedefs
  - function crc16_update_byte(crc, byte)
- One sub-module: uart_crc16_byte, a combinational byte-wise CRC-16 update (crc_in, data_in -> crc_out). It is instantiated in both TX and RX.
- TX/RX serializers stay inline in uart_crc_top.

Test Plan:
- Reset held low 2 cycles -> rx_ready_out=0, crc_valid_out=0, rx_data_out=0. No activity without tx_start.
- tx_data_in=8'hAA, pulse tx_start -> rx_ready_out rises within the latency bound; rx_data_out=8'hAA, crc_valid_out=1.
- Back-to-back frames 8'hCC, 8'hFF, 8'h55, 8'hAC, each started 100 cycles after the previous rx_ready_out -> each returns the same byte with crc_valid_out=1; rx_ready_out clears at each new start bit.
- tx_start pulsed again mid-frame with 8'h11 -> ignored; the frame completes with the original byte, and no second frame is received.
- uart_crc16_byte fed "123456789" from 16'hFFFF -> 16'h29B1.
- With UART_CRC_ERR_INJECT_EN: tx_data_in=8'hAA, err_inject_in=1 -> rx_data_out=8'hAB, crc_valid_out=0, rx_ready_out=1. Reset asserted mid-frame -> no rx_ready_out.

Source files
------------

// File: rtl/uart_crc_pkg.sv
// Shared types, constants and the CRC-16/CCITT byte update for the UART CRC loopback block.
package uart_crc_pkg;

   localparam logic [15:0] CRC16_POLY  = 16'h1021;
   localparam int          FRAME_BYTES = 3;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   // MSB-first, unreflected, no final XOR
   function automatic logic [15:0] crc16_update_byte(input logic [15:0] crc, input logic [7:0] data);
      logic [15:0] c;
      c = crc ^ {data, 8'h00};
      for (int i = 0; i < 8; i++) begin
         c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/uart_crc16_byte.sv
// Combinational byte-wise CRC-16/CCITT update, shared by the TX and RX paths.
module uart_crc16_byte
   import uart_crc_pkg::*;
(
   input  logic [15:0] crc_in,
   input  logic [7:0]  data_in,
   output logic [15:0] crc_out
);

   assign crc_out = crc16_update_byte(crc_in, data_in);

endmodule

// File: rtl/uart_crc_top.sv
// UART loopback with CRC-16: TX sends data + CRC over an internal line, RX re-checks it.
// Optional build macro UART_CRC_ERR_INJECT_EN adds err_inject_in to corrupt byte 0 bit 0 on the line.
//
// state    | meaning
// TX_IDLE  | line high, waiting for tx_start
// TX_START | driving start bit of current byte
// TX_DATA  | driving 8 data bits, LSB first
// TX_STOP  | driving stop bit, then next byte or idle
// RX_IDLE  | waiting for falling edge on the line
// RX_START | counting to mid start bit, glitch check
// RX_DATA  | sampling 8 data bits at mid-bit
// RX_STOP  | sampling stop bit, CRC update, completion
module uart_crc_top
   import uart_crc_pkg::*;
#(
   parameter int          CLKS_PER_BIT = 4,
   parameter logic [15:0] CRC_INIT     = 16'hFFFF
)(
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data_in,
   input  logic       tx_start,
`ifdef UART_CRC_ERR_INJECT_EN
   input  logic       err_inject_in,
`endif
   output logic [7:0] rx_data_out,
   output logic       rx_ready_out,
   output logic       crc_valid_out
);

   localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [1:0]  LAST_BYTE = 2'(FRAME_BYTES - 1);

   logic        inject;
   logic        serial_line;
   tx_state_t   tx_state;
   logic [15:0] tx_cnt;
   logic [2:0]  tx_bit;
   logic [1:0]  tx_byte;
   logic [7:0]  tx_shift;
   logic [15:0] tx_crc, tx_crc_next;

   rx_state_t   rx_state;
   logic        rx_prev;
   logic [15:0] rx_cnt;
   logic [2:0]  rx_bit;
   logic [1:0]  rx_byte;
   logic [7:0]  rx_shift, rx_byte0;
   logic [15:0] rx_crc, rx_crc_next;

`ifdef UART_CRC_ERR_INJECT_EN
   assign inject = err_inject_in;
`else
   assign inject = 1'b0;
`endif

   uart_crc16_byte u_tx_crc (.crc_in(CRC_INIT), .data_in(tx_data_in), .crc_out(tx_crc_next));
   uart_crc16_byte u_rx_crc (.crc_in(rx_crc),   .data_in(rx_shift),   .crc_out(rx_crc_next));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_state    <= TX_IDLE;
         serial_line <= 1'b1;
         tx_cnt      <= '0;
         tx_bit      <= '0;
         tx_byte     <= '0;
         tx_shift    <= '0;
         tx_crc      <= '0;
      end else begin
         case (tx_state)
            TX_IDLE: if (tx_start) begin
               tx_crc      <= tx_crc_next;
               tx_shift    <= tx_data_in ^ {7'd0, inject};
               serial_line <= 1'b0;
               tx_cnt      <= BIT_LAST;
               tx_byte     <= '0;
               tx_state    <= TX_START;
            end
            TX_START: if (tx_cnt == '0) begin
               serial_line <= tx_shift[0];
               tx_cnt      <= BIT_LAST;
               tx_bit      <= '0;
               tx_state    <= TX_DATA;
            end else tx_cnt <= tx_cnt - 16'd1;
            TX_DATA: if (tx_cnt == '0) begin
               tx_cnt <= BIT_LAST;
               if (tx_bit == 3'd7) begin
                  serial_line <= 1'b1;
                  tx_state    <= TX_STOP;
               end else begin
                  tx_bit      <= tx_bit + 3'd1;
                  tx_shift    <= {1'b0, tx_shift[7:1]};
                  serial_line <= tx_shift[1];
               end
            end else tx_cnt <= tx_cnt - 16'd1;
            TX_STOP: if (tx_cnt == '0) begin
               if (tx_byte == LAST_BYTE) begin
                  tx_state <= TX_IDLE;
               end else begin
                  tx_byte     <= tx_byte + 2'd1;
                  tx_shift    <= (tx_byte == 2'd0) ? tx_crc[15:8] : tx_crc[7:0];
                  serial_line <= 1'b0;
                  tx_cnt      <= BIT_LAST;
                  tx_state    <= TX_START;
               end
            end else tx_cnt <= tx_cnt - 16'd1;
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   // rx_byte stays nonzero between bytes of one frame so only the first start bit clears the flags
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_state      <= RX_IDLE;
         rx_prev       <= 1'b1;
         rx_cnt        <= '0;
         rx_bit        <= '0;
         rx_byte       <= '0;
         rx_shift      <= '0;
         rx_byte0      <= '0;
         rx_crc        <= '0;
         rx_data_out   <= '0;
         rx_ready_out  <= 1'b0;
         crc_valid_out <= 1'b0;
      end else begin
         rx_prev <= serial_line;
         case (rx_state)
            RX_IDLE: if (rx_prev && !serial_line) begin
               rx_cnt   <= HALF_LAST;
               rx_state <= RX_START;
               if (rx_byte == 2'd0) begin
                  rx_ready_out  <= 1'b0;
                  crc_valid_out <= 1'b0;
                  rx_crc        <= CRC_INIT;
               end
            end
            RX_START: if (rx_cnt == '0) begin
               if (serial_line) begin
                  rx_state <= RX_IDLE;
                  rx_byte  <= '0;
               end else begin
                  rx_cnt   <= BIT_LAST;
                  rx_bit   <= '0;
                  rx_state <= RX_DATA;
               end
            end else rx_cnt <= rx_cnt - 16'd1;
            RX_DATA: if (rx_cnt == '0) begin
               rx_shift <= {serial_line, rx_shift[7:1]};
               rx_cnt   <= BIT_LAST;
               if (rx_bit == 3'd7) rx_state <= RX_STOP;
               else                rx_bit   <= rx_bit + 3'd1;
            end else rx_cnt <= rx_cnt - 16'd1;
            RX_STOP: if (rx_cnt == '0) begin
               rx_state <= RX_IDLE;
               if (!serial_line) begin
                  rx_byte       <= '0;
                  rx_ready_out  <= 1'b1;
                  crc_valid_out <= 1'b0;
               end else begin
                  rx_crc <= rx_crc_next;
                  if (rx_byte == 2'd0) rx_byte0 <= rx_shift;
                  if (rx_byte == LAST_BYTE) begin
                     rx_byte       <= '0;
                     rx_data_out   <= rx_byte0;
                     rx_ready_out  <= 1'b1;
                     crc_valid_out <= (rx_crc_next == 16'h0000);
                  end else rx_byte <= rx_byte + 2'd1;
               end
            end else rx_cnt <= rx_cnt - 16'd1;
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_crc_top.sv
// Self-checking bench for uart_crc_top: table vectors, random frames, and multi-cycle corner cases.
module tb_uart_crc_top;

   localparam int          CPB  = 4;
   localparam logic [15:0] INIT = 16'hFFFF;
   localparam int          LAT  = 30*CPB - CPB/2 + 2;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] tx_data_in = 8'h00;
   logic       tx_start = 1'b0;
`ifdef UART_CRC_ERR_INJECT_EN
   logic       err_inject_in = 1'b0;
`endif
   logic [7:0] rx_data_out;
   logic       rx_ready_out;
   logic       crc_valid_out;

   logic [15:0] c_in, c_out;
   logic [7:0]  c_data;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   uart_crc_top #(.CLKS_PER_BIT(CPB), .CRC_INIT(INIT)) dut (
      .clk           (clk),
      .reset         (reset),
      .tx_data_in    (tx_data_in),
      .tx_start      (tx_start),
`ifdef UART_CRC_ERR_INJECT_EN
      .err_inject_in (err_inject_in),
`endif
      .rx_data_out   (rx_data_out),
      .rx_ready_out  (rx_ready_out),
      .crc_valid_out (crc_valid_out)
   );

   uart_crc16_byte u_crc (.crc_in(c_in), .data_in(c_data), .crc_out(c_out));

   typedef struct {
      logic [7:0] data;
      logic [7:0] exp_data;
      logic       exp_valid;
   } vec_t;

   // bit-serial reference: feed message bits one at a time into the shift register
   function automatic logic [15:0] ref_upd(input logic [15:0] crc, input logic [7:0] b);
      logic fb;
      for (int i = 7; i >= 0; i--) begin
         fb  = crc[15] ^ b[i];
         crc = {crc[14:0], 1'b0};
         if (fb) crc = crc ^ 16'h1021;
      end
      return crc;
   endfunction

   function automatic logic [29:0] ref_frame(input logic [7:0] line_byte, input logic [15:0] crc);
      logic [29:0] f;
      logic [7:0]  bytes [3];
      bytes[0] = line_byte;
      bytes[1] = crc[15:8];
      bytes[2] = crc[7:0];
      for (int j = 0; j < 3; j++) begin
         f[j*10] = 1'b0;
         for (int i = 0; i < 8; i++) f[j*10+1+i] = bytes[j][i];
         f[j*10+9] = 1'b1;
      end
      return f;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic chk_lat(input int lat);
      total++;
      if (lat < LAT - 1 || lat > LAT + 1) begin
         bad++;
         $display("FAIL latency actual=%0d required=%0d+-1", lat, LAT);
      end
   endtask

   // starts a frame, records the line each cycle, returns when rx_ready_out rises (bounded)
   task automatic run_frame(input logic [7:0] d, output int lat, output logic [29:0] seen);
      logic hist [0:399];
      tx_data_in = d;
      tx_start   = 1'b1;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
         tx_start = 1'b0;
`ifdef UART_CRC_ERR_INJECT_EN
         err_inject_in = 1'b0;
`endif
         hist[lat-1] = dut.serial_line;
         if (lat == 2) chk("ready_clear_at_start", 32'(rx_ready_out), 32'd0);
      end while ((lat < 3 || !rx_ready_out) && lat < 400);
      for (int k = 0; k < 30; k++) seen[k] = hist[k*CPB + CPB/2];
   endtask

   initial begin
      vec_t        vecs [5];
      int          lat, n;
      logic [29:0] seen;
      logic [15:0] c;
      logic [7:0]  d;
      string       s;

      vecs[0] = '{8'hAA, 8'hAA, 1'b1};
      vecs[1] = '{8'hCC, 8'hCC, 1'b1};
      vecs[2] = '{8'hFF, 8'hFF, 1'b1};
      vecs[3] = '{8'h55, 8'h55, 1'b1};
      vecs[4] = '{8'hAC, 8'hAC, 1'b1};

      repeat (2) @(posedge clk);
      #1;
      chk("reset_ready", 32'(rx_ready_out), 32'd0);
      chk("reset_valid", 32'(crc_valid_out), 32'd0);
      chk("reset_data", 32'(rx_data_out), 32'd0);
      chk("reset_line_idle", 32'(dut.serial_line), 32'd1);
      reset = 1'b1;
      repeat (50) @(posedge clk);
      #1;
      chk("idle_no_ready", 32'(rx_ready_out), 32'd0);
      chk("idle_line_high", 32'(dut.serial_line), 32'd1);

      s = "123456789";
      c = INIT;
      for (int i = 0; i < 9; i++) begin
         c_in = c; c_data = s[i]; #1;
         c = c_out;
      end
      chk("crc_check_value", 32'(c), 32'h29B1);
      for (int i = 0; i < 16; i++) begin
         c_in = 16'($urandom); c_data = 8'($urandom); #1;
         chk("crc_byte_random", 32'(c_out), 32'(ref_upd(c_in, c_data)));
      end

      for (int v = 0; v < 5; v++) begin
         run_frame(vecs[v].data, lat, seen);
         chk("vec_ready", 32'(rx_ready_out), 32'd1);
         chk("vec_data", 32'(rx_data_out), 32'(vecs[v].exp_data));
         chk("vec_valid", 32'(crc_valid_out), 32'(vecs[v].exp_valid));
         chk_lat(lat);
         chk("vec_line_bits", 32'(seen), 32'(ref_frame(vecs[v].data, ref_upd(INIT, vecs[v].data))));
         repeat (100) @(posedge clk);
         #1;
      end

      for (int r = 0; r < 6; r++) begin
         d = 8'($urandom);
         run_frame(d, lat, seen);
         chk("rand_data", 32'(rx_data_out), 32'(d));
         chk("rand_valid", 32'(crc_valid_out), 32'd1);
         chk_lat(lat);
         chk("rand_line_bits", 32'(seen), 32'(ref_frame(d, ref_upd(INIT, d))));
         repeat ($urandom_range(20, 60)) @(posedge clk);
         #1;
      end

      // second tx_start in the middle of a frame must be ignored
      tx_data_in = 8'h3C; tx_start = 1'b1;
      @(posedge clk); #1;
      tx_start = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      tx_data_in = 8'h11; tx_start = 1'b1;
      @(posedge clk); #1;
      tx_start = 1'b0;
      n = 0;
      while (!rx_ready_out && n < 300) begin
         @(posedge clk); #1; n++;
      end
      chk("midstart_ready", 32'(rx_ready_out), 32'd1);
      chk("midstart_data", 32'(rx_data_out), 32'h3C);
      chk("midstart_valid", 32'(crc_valid_out), 32'd1);
      repeat (200) @(posedge clk);
      #1;
      chk("midstart_no_second_frame", 32'(rx_ready_out), 32'd1);
      chk("midstart_data_held", 32'(rx_data_out), 32'h3C);

`ifdef UART_CRC_ERR_INJECT_EN
      err_inject_in = 1'b1;
      run_frame(8'hAA, lat, seen);
      chk("inject_ready", 32'(rx_ready_out), 32'd1);
      chk("inject_data", 32'(rx_data_out), 32'hAB);
      chk("inject_valid", 32'(crc_valid_out), 32'd0);
      chk("inject_line_bits", 32'(seen), 32'(ref_frame(8'hAB, ref_upd(INIT, 8'hAA))));
      repeat (50) @(posedge clk);
      #1;
`endif

      // reset in the middle of a frame: nothing reported afterwards
      tx_data_in = 8'h96; tx_start = 1'b1;
      @(posedge clk); #1;
      tx_start = 1'b0;
      repeat (50) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (200) @(posedge clk);
      #1;
      chk("midreset_no_ready", 32'(rx_ready_out), 32'd0);
      chk("midreset_data_cleared", 32'(rx_data_out), 32'd0);
      chk("midreset_line_idle", 32'(dut.serial_line), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
